// File: rtl/switch_debounce_strobe.sv
// Board switch conditioner: two-flop synchronisers, per-bit debouncers and a
// press-to-strobe FSM that emits one write pulse with captured data per press.
module switch_debounce_strobe #(
    parameter int unsigned DATA_W          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_raw,
    input  logic              we_sw_raw,
    output logic [DATA_W-1:0] sw_clean,
    output logic              we_level,
    output logic              wr_pulse,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int unsigned CH    = DATA_W + 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    logic [CH-1:0]    raw;
    logic [CH-1:0]    s1;
    logic [CH-1:0]    s2;
    logic [CH-1:0]    stable;
    logic [CNT_W-1:0] cnt [CH];
    state_t           state;

    // Write-enable occupies the top channel, data switches the rest.
    assign raw = {we_sw_raw, sw_raw};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Each channel accepts a new level only after it differs for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < int'(CH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign sw_clean = stable[DATA_W-1:0];
    assign we_level = stable[DATA_W];

    // Press FSM: strobe once on the debounced rising level, then wait for release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_pulse <= 1'b0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (we_level) begin
                        state    <= STROBE;
                        wr_pulse <= 1'b1;
                        wr_data  <= sw_clean;
                        busy     <= 1'b1;
                    end
                end
                STROBE: begin
                    if (we_level) begin
                        state <= HOLD;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!we_level) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debounce_strobe.sv
// Directed bench: a DEBOUNCE_CYCLES=4 instance and a DEBOUNCE_CYCLES=1
// instance share stimulus; expected values are hand-computed cycle counts.
module tb_switch_debounce_strobe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sw_raw;
    logic       we_sw_raw;

    logic [1:0] sw_clean4, wr_data4, sw_clean1, wr_data1;
    logic       we_level4, wr_pulse4, busy4, we_level1, wr_pulse1, busy1;

    int checks   = 0;
    int failures = 0;
    int pulses4  = 0;
    int pulses1  = 0;

    always #5 clk = ~clk;

    switch_debounce_strobe #(.DATA_W(2), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .we_sw_raw(we_sw_raw),
        .sw_clean(sw_clean4), .we_level(we_level4), .wr_pulse(wr_pulse4),
        .wr_data(wr_data4), .busy(busy4)
    );

    switch_debounce_strobe #(.DATA_W(2), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .we_sw_raw(we_sw_raw),
        .sw_clean(sw_clean1), .we_level(we_level1), .wr_pulse(wr_pulse1),
        .wr_data(wr_data1), .busy(busy1)
    );

    always @(negedge clk) begin
        if (wr_pulse4) pulses4++;
        if (wr_pulse1) pulses1++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset with raw inputs high
        rst_n = 1'b0; sw_raw = 2'b11; we_sw_raw = 1'b1;
        tick(5);
        chk("rst_sw_clean4", 32'(sw_clean4), 32'd0);
        chk("rst_we_level4", 32'(we_level4), 32'd0);
        chk("rst_wr_pulse4", 32'(wr_pulse4), 32'd0);
        chk("rst_wr_data4",  32'(wr_data4),  32'd0);
        chk("rst_busy4",     32'(busy4),     32'd0);
        chk("rst_sw_clean1", 32'(sw_clean1), 32'd0);
        chk("rst_busy1",     32'(busy1),     32'd0);
        sw_raw = 2'b00; we_sw_raw = 1'b0; rst_n = 1'b1;
        tick(10);
        chk("idle_busy4", 32'(busy4), 32'd0);
        pulses4 = 0;

        // 2. clean press
        sw_raw = 2'b10;
        tick(8);
        chk("t2_sw_clean", 32'(sw_clean4), 32'd2);
        we_sw_raw = 1'b1;
        tick(5);
        chk("t2_we_lvl_5", 32'(we_level4), 32'd0);
        tick(1);
        chk("t2_we_lvl_6", 32'(we_level4), 32'd1);
        chk("t2_pulse_6",  32'(wr_pulse4), 32'd0);
        tick(1);
        chk("t2_pulse_7",  32'(wr_pulse4), 32'd1);
        chk("t2_wr_data",  32'(wr_data4),  32'd2);
        chk("t2_busy_7",   32'(busy4),     32'd1);
        tick(1);
        chk("t2_pulse_8",  32'(wr_pulse4), 32'd0);
        chk("t2_busy_8",   32'(busy4),     32'd1);
        tick(12);
        chk("t2_npulse",   32'(pulses4),   32'd1);
        chk("t2_busy_hold", 32'(busy4),    32'd1);
        we_sw_raw = 1'b0;
        tick(6);
        chk("t2_rel_lvl",  32'(we_level4), 32'd0);
        chk("t2_rel_busy6", 32'(busy4),    32'd1);
        tick(1);
        chk("t2_rel_busy7", 32'(busy4),    32'd0);
        chk("t2_data_keep", 32'(wr_data4), 32'd2);

        // 3. bouncing write-enable
        pulses4 = 0;
        for (int k = 0; k < 6; k++) begin
            we_sw_raw = ~we_sw_raw;
            tick(2);
        end
        we_sw_raw = 1'b1;
        tick(5);
        chk("t3_no_pulse", 32'(pulses4),   32'd0);
        chk("t3_lvl_5",    32'(we_level4), 32'd0);
        tick(1);
        chk("t3_lvl_6",    32'(we_level4), 32'd1);
        tick(1);
        chk("t3_pulse_7",  32'(wr_pulse4), 32'd1);
        tick(5);
        chk("t3_npulse",   32'(pulses4),   32'd1);
        we_sw_raw = 1'b0;
        tick(8);
        chk("t3_idle",     32'(busy4),     32'd0);

        // 4. glitch rejection on data
        sw_raw = 2'b00;
        tick(8);
        chk("t4_base", 32'(sw_clean4), 32'd0);
        sw_raw = 2'b11;
        tick(3);
        sw_raw = 2'b00;
        tick(3);
        chk("t4_mid",  32'(sw_clean4), 32'd0);
        tick(7);
        chk("t4_end",  32'(sw_clean4), 32'd0);

        // 5. data change while held
        pulses4 = 0;
        sw_raw = 2'b01;
        tick(8);
        chk("t5_sw01", 32'(sw_clean4), 32'd1);
        we_sw_raw = 1'b1;
        tick(7);
        chk("t5_pulse1", 32'(wr_pulse4), 32'd1);
        chk("t5_data1",  32'(wr_data4),  32'd1);
        tick(2);
        chk("t5_hold",   32'(busy4),     32'd1);
        sw_raw = 2'b11;
        tick(8);
        chk("t5_sw11",   32'(sw_clean4), 32'd3);
        chk("t5_data_keep", 32'(wr_data4), 32'd1);
        chk("t5_one_pulse", 32'(pulses4),  32'd1);
        we_sw_raw = 1'b0;
        tick(8);
        chk("t5_rel",    32'(busy4),     32'd0);
        we_sw_raw = 1'b1;
        tick(7);
        chk("t5_pulse2", 32'(wr_pulse4), 32'd1);
        chk("t5_data2",  32'(wr_data4),  32'd3);
        tick(3);
        chk("t5_npulse", 32'(pulses4),   32'd2);
        chk("t5_hold2",  32'(busy4),     32'd1);

        // 6. reset while held, write-enable stays high through release
        rst_n = 1'b0;
        tick(2);
        chk("t6_rst_busy",  32'(busy4),     32'd0);
        chk("t6_rst_lvl",   32'(we_level4), 32'd0);
        chk("t6_rst_data",  32'(wr_data4),  32'd0);
        chk("t6_rst_sw",    32'(sw_clean4), 32'd0);
        chk("t6_rst_busy1", 32'(busy1),     32'd0);
        pulses4 = 0; pulses1 = 0;
        rst_n = 1'b1;
        tick(2);
        chk("t6_d1_lvl_2",   32'(we_level1), 32'd0);
        tick(1);
        chk("t6_d1_lvl_3",   32'(we_level1), 32'd1);
        tick(1);
        chk("t6_d1_pulse_4", 32'(wr_pulse1), 32'd1);
        chk("t6_d1_data",    32'(wr_data1),  32'd3);
        chk("t6_d4_lvl_4",   32'(we_level4), 32'd0);
        tick(1);
        chk("t6_d4_lvl_5",   32'(we_level4), 32'd0);
        tick(1);
        chk("t6_d4_lvl_6",   32'(we_level4), 32'd1);
        chk("t6_d4_pulse_6", 32'(wr_pulse4), 32'd0);
        tick(1);
        chk("t6_d4_pulse_7", 32'(wr_pulse4), 32'd1);
        chk("t6_d4_data",    32'(wr_data4),  32'd3);
        tick(5);
        chk("t6_np4", 32'(pulses4), 32'd1);
        chk("t6_np1", 32'(pulses1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
